dm_access_ctrl: RTL and testbench

Sequencer and two-port arbiter in front of the single-port data memory (DM). After reset it sweeps the memory to zero one word per cycle, so the memory itself needs no bulk reset. It then shares the memory between port 0 (pipeline MEM stage) and port 1 (debug/DMA loader) with round-robin arbitration. It also blocks misaligned and out-of-range accesses.

---
 rtl/dm_access_ctrl_pkg.sv | 25 ++
 rtl/dm_access_ctrl_if.sv | 45 ++++
 rtl/dm_access_ctrl_rr_arb2.sv | 38 +++
 rtl/dm_access_ctrl.sv | 127 ++++++++++++
 tb/tb_dm_access_ctrl.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dm_access_ctrl_pkg.sv
// Shared types and defaults for the data-memory access controller.
// Holds the FSM state encoding, default geometry and the address legality check.
// No logic or state of its own.
package dm_access_ctrl_pkg;

    localparam int DMC_ADDR_W = 12;
    localparam int DMC_DEPTH  = 4096;

    typedef enum logic {
        DMC_CLEAR = 1'b0,
        DMC_RUN   = 1'b1
    } dmc_state_e;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dmc_req_t;

    // Word aligned and inside the 2^addr_w-word window.
    function automatic logic addr_ok(input logic [31:0] addr, input int unsigned addr_w);
        return (addr[1:0] == 2'b00) && ((addr >> (addr_w + 2)) == 32'd0);
    endfunction

endpackage

// File: rtl/dm_access_ctrl_if.sv
// Bundle of requester, status and memory-side signals of dm_access_ctrl.
// slave = the controller, master = requesters plus the memory read data.
// Requests are held until granted; responses cannot be stalled.
interface dm_access_ctrl_if #(
    parameter int ADDR_W = dm_access_ctrl_pkg::DMC_ADDR_W
) ();

    logic              clr_req;
    logic              p0_req;
    logic              p1_req;
    logic              p0_we;
    logic              p1_we;
    logic [31:0]       p0_addr;
    logic [31:0]       p1_addr;
    logic [31:0]       p0_wdata;
    logic [31:0]       p1_wdata;
    logic              p0_gnt;
    logic              p1_gnt;
    logic              p0_rvalid;
    logic              p1_rvalid;
    logic [31:0]       p0_rdata;
    logic [31:0]       p1_rdata;
    logic              busy;
    logic              err;
    logic              err_port;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  clr_req, p0_req, p1_req, p0_we, p1_we,
        input  p0_addr, p1_addr, p0_wdata, p1_wdata, mem_rdata,
        output p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_rdata, p1_rdata,
        output busy, err, err_port, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output clr_req, p0_req, p1_req, p0_we, p1_we,
        output p0_addr, p1_addr, p0_wdata, p1_wdata, mem_rdata,
        input  p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_rdata, p1_rdata,
        input  busy, err, err_port, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/dm_access_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; a tie goes to the port not granted last.
// Latency: combinational grant, 'last' pointer updates on the granting edge.
// Backpressure: requesters hold req until granted; en=0 suppresses all grants.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic last_q;
    logic last_d;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            gnt[0] = req[0] & (~req[1] | last_q);
            gnt[1] = req[1] & (~req[0] | ~last_q);
        end
        last_d = last_q;
        if (gnt[1]) begin
            last_d = 1'b1;
        end else if (gnt[0]) begin
            last_d = 1'b0;
        end
    end

    // Starts at 1 so port 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/dm_access_ctrl.sv
// Clears the data memory after reset, then arbitrates it between two ports.
// Latency: grant same cycle, rvalid/err one cycle after grant, clear = DEPTH cycles.
// Backpressure: requesters wait (req held) while busy or while losing arbitration.
module dm_access_ctrl import dm_access_ctrl_pkg::*; #(
    parameter int ADDR_W = DMC_ADDR_W,
    parameter int DEPTH  = DMC_DEPTH
) (
    input  logic           clk,
    input  logic           rst_n,
    dm_access_ctrl_if.slave bus
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    dmc_state_e        state_q;
    logic [ADDR_W-1:0] clr_idx_q;

    logic [1:0]  gnt;
    logic        gnt_any;
    logic        sel_port;
    logic        sel_ok;
    dmc_req_t    p0_r;
    dmc_req_t    p1_r;
    dmc_req_t    sel;

    logic        p0_rvalid_q;
    logic        p1_rvalid_q;
    logic [31:0] p0_rdata_q;
    logic [31:0] p1_rdata_q;
    logic        err_q;
    logic        err_port_q;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state_q == DMC_RUN),
        .req   ({bus.p1_req, bus.p0_req}),
        .gnt   (gnt)
    );

    assign p0_r     = '{we: bus.p0_we, addr: bus.p0_addr, wdata: bus.p0_wdata};
    assign p1_r     = '{we: bus.p1_we, addr: bus.p1_addr, wdata: bus.p1_wdata};
    assign gnt_any  = |gnt;
    assign sel_port = gnt[1];
    assign sel      = sel_port ? p1_r : p0_r;
    assign sel_ok   = addr_ok(sel.addr, ADDR_W);

    // A rejected access is still granted so the requester is released, but never reaches memory.
    always_comb begin
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (state_q == DMC_CLEAR) begin
            bus.mem_we   = 1'b1;
            bus.mem_addr = clr_idx_q;
        end else if (gnt_any && sel_ok) begin
            bus.mem_we    = sel.we;
            bus.mem_addr  = sel.addr[ADDR_W+1:2];
            bus.mem_wdata = sel.wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= DMC_CLEAR;
            clr_idx_q <= '0;
        end else begin
            case (state_q)
                DMC_CLEAR: begin
                    if (bus.clr_req) begin
                        clr_idx_q <= '0;
                    end else if (clr_idx_q == LAST_IDX) begin
                        state_q   <= DMC_RUN;
                        clr_idx_q <= '0;
                    end else begin
                        clr_idx_q <= clr_idx_q + ADDR_W'(1);
                    end
                end
                DMC_RUN: begin
                    if (bus.clr_req) begin
                        state_q   <= DMC_CLEAR;
                        clr_idx_q <= '0;
                    end
                end
                default: begin
                    state_q   <= DMC_CLEAR;
                    clr_idx_q <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p0_rvalid_q <= 1'b0;
            p1_rvalid_q <= 1'b0;
            p0_rdata_q  <= '0;
            p1_rdata_q  <= '0;
            err_q       <= 1'b0;
            err_port_q  <= 1'b0;
        end else begin
            p0_rvalid_q <= gnt[0] & ~bus.p0_we;
            p1_rvalid_q <= gnt[1] & ~bus.p1_we;
            if (gnt[0] && !bus.p0_we) begin
                p0_rdata_q <= sel_ok ? bus.mem_rdata : 32'd0;
            end
            if (gnt[1] && !bus.p1_we) begin
                p1_rdata_q <= sel_ok ? bus.mem_rdata : 32'd0;
            end
            err_q <= gnt_any & ~sel_ok;
            if (gnt_any && !sel_ok) begin
                err_port_q <= sel_port;
            end
        end
    end

    assign bus.p0_gnt    = gnt[0];
    assign bus.p1_gnt    = gnt[1];
    assign bus.p0_rvalid = p0_rvalid_q;
    assign bus.p1_rvalid = p1_rvalid_q;
    assign bus.p0_rdata  = p0_rdata_q;
    assign bus.p1_rdata  = p1_rdata_q;
    assign bus.err       = err_q;
    assign bus.err_port  = err_port_q;
    assign bus.busy      = (state_q == DMC_CLEAR);

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Bench for dm_access_ctrl: directed stimulus with a queue-based response scoreboard.
module tb_dm_access_ctrl;

    localparam int ADDR_W = 12;
    localparam int DEPTH  = 4096;

    typedef struct {
        bit          port;
        bit          is_err;
        logic [31:0] data;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    logic [31:0] dm [0:DEPTH-1];

    dm_access_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    dm_access_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Data memory beside the controller: asynchronous read, synchronous write.
    assign bus.mem_rdata = dm[bus.mem_addr];
    always @(posedge clk) begin
        if (bus.mem_we) dm[bus.mem_addr] <= bus.mem_wdata;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_rd(input bit port, input logic [31:0] data);
        exp_q.push_back('{port: port, is_err: 1'b0, data: data});
    endtask

    task automatic expect_err(input bit port);
        exp_q.push_back('{port: port, is_err: 1'b1, data: 32'd0});
    endtask

    task automatic pop_cmp(input bit is_err, input bit port, input logic [31:0] data);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_response: err=%0b port=%0d data=%h with nothing expected (t=%0t)",
                     is_err, port, data, $time);
        end else begin
            e = exp_q.pop_front();
            if (e.is_err != is_err || e.port != port || e.data !== data) begin
                errors++;
                $display("FAIL response: got err=%0b port=%0d data=%h expected err=%0b port=%0d data=%h (t=%0t)",
                         is_err, port, data, e.is_err, e.port, e.data, $time);
            end
        end
    endtask

    // Monitor: registered responses are sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.p0_rvalid) pop_cmp(1'b0, 1'b0, bus.p0_rdata);
            if (bus.p1_rvalid) pop_cmp(1'b0, 1'b1, bus.p1_rdata);
            if (bus.err)       pop_cmp(1'b1, bus.err_port, 32'd0);
        end
    end

    task automatic idle();
        bus.clr_req = 1'b0;
        bus.p0_req = 1'b0; bus.p0_we = 1'b0; bus.p0_addr = '0; bus.p0_wdata = '0;
        bus.p1_req = 1'b0; bus.p1_we = 1'b0; bus.p1_addr = '0; bus.p1_wdata = '0;
    endtask

    task automatic drive(input bit port, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
        if (port == 1'b0) begin
            bus.p0_req = 1'b1; bus.p0_we = we; bus.p0_addr = addr; bus.p0_wdata = wdata;
        end else begin
            bus.p1_req = 1'b1; bus.p1_we = we; bus.p1_addr = addr; bus.p1_wdata = wdata;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"},      bus.busy, 1);
        chk({tag, "_gnt"},       {bus.p1_gnt, bus.p0_gnt}, 0);
        chk({tag, "_rvalid"},    {bus.p1_rvalid, bus.p0_rvalid}, 0);
        chk({tag, "_err"},       {bus.err_port, bus.err}, 0);
        chk({tag, "_p0_rdata"},  bus.p0_rdata, 0);
        chk({tag, "_p1_rdata"},  bus.p1_rdata, 0);
        chk({tag, "_mem_we"},    bus.mem_we, 1);
        chk({tag, "_mem_addr"},  bus.mem_addr, 0);
        chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bad;
        int n;
        for (int i = 0; i < DEPTH; i++) dm[i] = 32'hDEAD_BEEF;
        idle();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("reset");

        // Initial sweep: one word per cycle, no grants even with nothing requested.
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i > 0) begin @(negedge clk); #1; end
            if (bus.busy !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 12'(i) ||
                bus.mem_wdata !== 32'd0) bad++;
        end
        chk("sweep_bad_cycles", bad, 0);
        @(negedge clk); #1;
        chk("busy_after_sweep", bus.busy, 0);
        chk("idle_mem_we", bus.mem_we, 0);
        chk("idle_mem_addr", bus.mem_addr, 0);

        // p0 write then read back of 0x10.
        drive(0, 1, 32'h10, 32'h1234_5678); #1;
        chk("wr10_gnt", bus.p0_gnt, 1);
        chk("wr10_mem_we", bus.mem_we, 1);
        chk("wr10_mem_addr", bus.mem_addr, 4);
        chk("wr10_mem_wdata", bus.mem_wdata, 32'h1234_5678);
        @(negedge clk);
        drive(0, 0, 32'h10, 32'h0); #1;
        chk("rd10_gnt", bus.p0_gnt, 1);
        chk("rd10_mem_we", bus.mem_we, 0);
        chk("rd10_mem_addr", bus.mem_addr, 4);
        expect_rd(0, 32'h1234_5678);
        @(negedge clk);
        idle();
        drive(1, 1, 32'h20, 32'hCAFE_F00D); #1;
        chk("rd10_rvalid_next", bus.p0_rvalid, 1);
        chk("wr20_p1_gnt", bus.p1_gnt, 1);
        chk("wr20_mem_addr", bus.mem_addr, 8);

        // Contention: p1 was granted last, so p0 wins first and grants alternate.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            idle();
            drive(0, 0, 32'h10, 32'h0);
            drive(1, 0, 32'h20, 32'h0);
            #1;
            chk($sformatf("rr_p0_gnt_%0d", k), bus.p0_gnt, (k % 2 == 0) ? 1 : 0);
            chk($sformatf("rr_p1_gnt_%0d", k), bus.p1_gnt, (k % 2 == 1) ? 1 : 0);
            if (k % 2 == 0) expect_rd(0, 32'h1234_5678);
            else            expect_rd(1, 32'hCAFE_F00D);
        end

        // Misaligned and out-of-range writes from p1.
        @(negedge clk);
        idle();
        drive(1, 1, 32'h13, 32'hFFFF_FFFF); #1;
        chk("bad13_gnt", bus.p1_gnt, 1);
        chk("bad13_mem_we", bus.mem_we, 0);
        expect_err(1);
        @(negedge clk);
        drive(1, 1, 32'h0001_0000, 32'hFFFF_FFFF); #1;
        chk("bad10000_gnt", bus.p1_gnt, 1);
        chk("bad10000_mem_we", bus.mem_we, 0);
        chk("bad13_err_next", bus.err, 1);
        expect_err(1);
        @(negedge clk);
        idle(); #1;
        chk("bad10000_err_next", bus.err, 1);
        chk("bad10000_err_port", bus.err_port, 1);
        @(negedge clk);
        drive(0, 0, 32'h10, 32'h0); #1;
        chk("unchanged_rd_gnt", bus.p0_gnt, 1);
        expect_rd(0, 32'h1234_5678);

        // clr_req alongside a write: the write completes, then a full sweep.
        @(negedge clk);
        idle();
        bus.clr_req = 1'b1;
        drive(0, 1, 32'h8, 32'h55AA_55AA); #1;
        chk("clrwr_gnt", bus.p0_gnt, 1);
        chk("clrwr_mem_we", bus.mem_we, 1);
        chk("clrwr_mem_addr", bus.mem_addr, 2);
        @(negedge clk);
        idle(); #1;
        chk("clr_busy", bus.busy, 1);
        chk("clr_mem_addr0", bus.mem_addr, 0);
        n = 0;
        while (bus.busy && n < 6000) begin
            @(negedge clk); #1;
            n++;
        end
        chk("clr_sweep_len", n, DEPTH);
        drive(0, 0, 32'h8, 32'h0); #1;
        chk("rd8_gnt", bus.p0_gnt, 1);
        expect_rd(0, 32'h0);

        // Reset 100 cycles into a sweep with p0 held requesting.
        @(negedge clk);
        idle();
        bus.clr_req = 1'b1;
        @(negedge clk);
        idle();
        drive(0, 0, 32'h10, 32'h0);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            if (bus.p0_gnt !== 1'b0 || bus.mem_addr !== 12'(i)) bad++;
        end
        chk("midsweep_bad_cycles", bad, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1 chk_reset_outputs("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n = 0;
        while (!bus.p0_gnt && n < 6000) begin
            @(negedge clk); #1;
            n++;
        end
        chk("post_reset_first_gnt", n, DEPTH);
        expect_rd(0, 32'h0);
        @(negedge clk);
        idle();

        repeat (3) @(negedge clk);
        #1 chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
